// File: rtl/score_fill_controller.sv
// Sequencer for a score-matrix fill: row-0/column-0 init, then per-cell read/max/write.
// Ports: clk, rst, start, signal, max_in, max_valid -> init/read/max/write strobes, addr, i, j, max, busy, done.
module score_fill_controller #(
  parameter int N       = 128,
  parameter int GAP     = -2,
  parameter int BitAddr = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signal,
  input  logic [8:0]         max_in,
  input  logic               max_valid,
  output logic               en_init,
  output logic               init_col,
  output logic [BitAddr:0]   addr,
  output logic [8:0]         data_init,
  output logic               en_read,
  output logic               en_counter_3,
  output logic               max_req,
  output logic               we,
  output logic               en_ins,
  output logic [8:0]         max,
  output logic [BitAddr:0]   i,
  output logic [BitAddr:0]   j,
  output logic               busy,
  output logic               done
);

  localparam int AbsGap = (GAP < 0) ? -GAP : GAP;
  localparam logic [BitAddr:0] LastIdx = N[BitAddr:0];
  localparam logic [BitAddr:0] One = {{BitAddr{1'b0}}, 1'b1};
  localparam logic [8:0] GapStep = GAP[8:0];

  if (N * AbsGap > 256) begin : g_range_err
    $error("score_fill_controller: N*|GAP| exceeds 256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_MAX,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [BitAddr:0] r_k;
  logic             r_col;
  logic [8:0]       r_data;
  logic [BitAddr:0] r_i;
  logic [BitAddr:0] r_j;
  logic [8:0]       r_max;
  logic             w_k_last;
  logic             w_i_last;
  logic             w_j_last;

  assign w_k_last  = (r_k == LastIdx);
  assign w_i_last  = (r_i == LastIdx);
  assign w_j_last  = (r_j == LastIdx);
  assign addr      = r_k;
  assign init_col  = r_col;
  assign data_init = r_data;
  assign i         = r_i;
  assign j         = r_j;
  assign max       = r_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    en_init      = 1'b0;
    en_read      = 1'b0;
    en_counter_3 = 1'b0;
    max_req      = 1'b0;
    we           = 1'b0;
    en_ins       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_INIT;
      end
      S_INIT: begin
        en_init = 1'b1;
        we      = 1'b1;
        busy    = 1'b1;
        if (r_col && w_k_last) w_next = S_READ;
      end
      S_READ: begin
        en_read      = 1'b1;
        en_counter_3 = 1'b1;
        busy         = 1'b1;
        if (signal) w_next = S_MAX;
      end
      S_MAX: begin
        max_req = 1'b1;
        busy    = 1'b1;
        if (max_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        we     = 1'b1;
        en_ins = 1'b1;
        busy   = 1'b1;
        w_next = (w_i_last && w_j_last) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Each init index is issued twice (row 0, then column 0); the score
  // accumulator steps by GAP once per index so it wraps like k*GAP mod 512.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_col  <= 1'b0;
      r_data <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_max  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k    <= '0;
            r_col  <= 1'b0;
            r_data <= '0;
          end
        end
        S_INIT: begin
          if (!r_col) begin
            r_col <= 1'b1;
          end else if (w_k_last) begin
            r_col  <= 1'b0;
            r_k    <= '0;
            r_data <= '0;
            r_i    <= One;
            r_j    <= One;
          end else begin
            r_col  <= 1'b0;
            r_k    <= r_k + One;
            r_data <= r_data + GapStep;
          end
        end
        S_MAX: begin
          if (max_valid) r_max <= max_in;
        end
        S_WRITE: begin
          if (!w_j_last) begin
            r_j <= r_j + One;
          end else if (!w_i_last) begin
            r_j <= One;
            r_i <= r_i + One;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_fill_controller.sv
// Bench for score_fill_controller (N=4, GAP=-2): randomized read/max timing
// checked cycle by cycle against expectations computed from the fill rules.
module tb_score_fill_controller;

  localparam int N   = 4;
  localparam int GAP = -2;
  localparam int BA  = $clog2(N + 1);

  localparam logic [7:0] S_IDLE  = 8'b0000_0000;
  localparam logic [7:0] S_INIT  = 8'b1100_0001;
  localparam logic [7:0] S_READ  = 8'b0001_1001;
  localparam logic [7:0] S_MAX   = 8'b0000_0101;
  localparam logic [7:0] S_WRITE = 8'b0110_0001;
  localparam logic [7:0] S_DONE  = 8'b0000_0010;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signal;
  logic [8:0]    max_in;
  logic          max_valid;
  logic          en_init;
  logic          init_col;
  logic [BA:0]   addr;
  logic [8:0]    data_init;
  logic          en_read;
  logic          en_counter_3;
  logic          max_req;
  logic          we;
  logic          en_ins;
  logic [8:0]    max;
  logic [BA:0]   i;
  logic [BA:0]   j;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  logic [8:0] last_max;

  wire [7:0] strobes = {en_init, we, en_ins, en_read, en_counter_3,
                        max_req, done, busy};

  always #5 clk = ~clk;

  score_fill_controller #(.N(N), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .signal(signal),
    .max_in(max_in), .max_valid(max_valid),
    .en_init(en_init), .init_col(init_col), .addr(addr),
    .data_init(data_init), .en_read(en_read),
    .en_counter_3(en_counter_3), .max_req(max_req),
    .we(we), .en_ins(en_ins), .max(max), .i(i), .j(j),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [8:0] score9(input int v);
    logic [8:0] r;
    r = v[8:0];
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strb"}, {24'b0, strobes}, 32'h0);
    chk({tag, "_addr"}, {28'b0, addr}, 32'h0);
    chk({tag, "_col"}, {31'b0, init_col}, 32'h0);
    chk({tag, "_data"}, {23'b0, data_init}, 32'h0);
    chk({tag, "_ij"}, {24'b0, i, j}, 32'h0);
    chk({tag, "_max"}, {23'b0, max}, 32'h0);
  endtask

  // One complete fill starting from an IDLE negedge. hold keeps start high
  // throughout; abort fires an asynchronous reset in MAX of cell (2,3).
  task automatic fill(input bit hold, input bit abort);
    int rd;
    int md;
    int ei;
    int ej;
    logic [8:0] mv;
    start = 1'b1;
    for (int m = 0; m < 2 * (N + 1); m++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("init_strb", {24'b0, strobes}, {24'b0, S_INIT});
      chk("init_addr", {28'b0, addr}, m / 2);
      chk("init_col", {31'b0, init_col}, m % 2);
      chk("init_data", {23'b0, data_init}, {23'b0, score9((m / 2) * GAP)});
    end
    for (int c = 0; c < N * N; c++) begin
      ei = c / N + 1;
      ej = c % N + 1;
      rd = $urandom_range(0, 4);
      for (int r = 0; r <= rd; r++) begin
        @(negedge clk);
        chk("read_strb", {24'b0, strobes}, {24'b0, S_READ});
        chk("read_ij", {24'b0, i, j}, (ei << 4) | ej);
        if (!hold) start = 1'($urandom_range(0, 1));
        signal    = (r == rd);
        max_valid = 1'($urandom_range(0, 1));
        max_in    = 9'($urandom);
      end
      md = $urandom_range(0, 5);
      mv = 9'($urandom);
      for (int r = 0; r <= md; r++) begin
        @(negedge clk);
        chk("max_strb", {24'b0, strobes}, {24'b0, S_MAX});
        if (abort && ei == 2 && ej == 3) begin
          #2 rst = 1'b1;
          #1;
          chk_all_zero("async_rst");
          start = 1'b1;
          @(negedge clk);
          chk("rst_hold", {24'b0, strobes}, {24'b0, S_IDLE});
          rst       = 1'b0;
          start     = 1'b0;
          signal    = 1'b1;
          max_valid = 1'b1;
          @(negedge clk);
          chk_all_zero("no_resume");
          signal    = 1'b0;
          max_valid = 1'b0;
          return;
        end
        signal    = 1'($urandom_range(0, 1));
        max_valid = (r == md);
        max_in    = (r == md) ? mv : 9'($urandom);
      end
      @(negedge clk);
      if (!hold) start = 1'b0;
      max_valid = 1'b0;
      signal    = 1'($urandom_range(0, 1));
      chk("write_strb", {24'b0, strobes}, {24'b0, S_WRITE});
      chk("write_ij", {24'b0, i, j}, (ei << 4) | ej);
      chk("write_max", {23'b0, max}, {23'b0, mv});
      last_max = mv;
    end
    @(negedge clk);
    signal = 1'b0;
    chk("done_strb", {24'b0, strobes}, {24'b0, S_DONE});
    @(negedge clk);
    chk("after_strb", {24'b0, strobes}, {24'b0, S_IDLE});
    chk("after_ij", {24'b0, i, j}, (N << 4) | N);
    chk("after_max", {23'b0, max}, {23'b0, last_max});
    if (!hold) begin
      signal = 1'b1;
      @(negedge clk);
      signal = 1'b0;
      chk("idle_signal", {24'b0, strobes}, {24'b0, S_IDLE});
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    signal    = 1'b0;
    max_in    = '0;
    max_valid = 1'b0;
    last_max  = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_strb", {24'b0, strobes}, {24'b0, S_IDLE});
    fill(1'b0, 1'b0);
    fill(1'b0, 1'b1);
    fill(1'b0, 1'b0);
    fill(1'b1, 1'b0);
    fill(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_fill_controller.md
SCORE_FILL_CONTROLLER -- requirements
Module: score_fill_controller

Interface
REQ-001 SHALL have parameter N, default 128: sequence length; matrix is (N+1)x(N+1).
REQ-002 SHALL have parameter GAP, default -2: signed gap penalty used for row-0/column-0 initialisation.
REQ-003 SHALL have derived parameter BitAddr = $clog2(N+1); every index/address port is [BitAddr:0].
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1: level request to begin a full matrix fill.
REQ-007 SHALL have port signal, input, 1: from score manager; high for one cycle when the diag/left/up read triple is complete.
REQ-008 SHALL have port max_in, input, 9: signed cell score from the max unit.
REQ-009 SHALL have port max_valid, input, 1: max_in is valid this cycle.
REQ-010 SHALL have port en_init, output, 1: initialisation write strobe.
REQ-011 SHALL have port init_col, output, 1: 0 = row-0 init write, 1 = column-0 init write.
REQ-012 SHALL have port addr, output, BitAddr+1: init index k.
REQ-013 SHALL have port data_init, output, 9: init score k*GAP.
REQ-014 SHALL have ports en_read and en_counter_3, output, 1 each: read-triple enables.
REQ-015 SHALL have port max_req, output, 1: request to max unit.
REQ-016 SHALL have ports we and en_ins, output, 1 each: cell write strobes.
REQ-017 SHALL have port max, output, 9: registered score to write.
REQ-018 SHALL have ports i and j, output, BitAddr+1 each: current cell.
REQ-019 SHALL have ports busy and done, output, 1 each.

Function
REQ-020 SHALL implement states IDLE, INIT, READ, MAX, WRITE, DONE.
REQ-021 IDLE: start=1 SHALL move to INIT next edge with k=0, init_col=0; start ignored in all other states.
REQ-022 INIT: SHALL assert en_init and we every cycle for 2(N+1) cycles; each k=0..N issued twice, init_col=0 then 1; data_init = k*GAP truncated to 9-bit two's complement.
REQ-023 After k=N, init_col=1, SHALL enter READ with i=1, j=1.
REQ-024 READ: SHALL hold en_read=en_counter_3=1 until the cycle signal=1 is sampled, then enter MAX; signal outside READ SHALL be ignored.
REQ-025 MAX: SHALL hold max_req=1 until max_valid=1, capture max_in into max on that edge, enter WRITE; max_valid and signal in the same READ cycle: max_valid ignored.
REQ-026 WRITE: SHALL assert we=en_ins=1 for exactly one cycle with i, j, max stable.
REQ-027 At end of WRITE: j<N -> j+1, READ; j=N and i<N -> j=1, i+1, READ; i=j=N -> DONE.
REQ-028 DONE: SHALL pulse done=1 for one cycle, then IDLE; i, j, max hold last values.
REQ-029 busy SHALL be 1 in INIT, READ, MAX, WRITE; 0 in IDLE, DONE.
REQ-030 Strobes en_init, we, en_ins, en_read, en_counter_3, max_req SHALL be mutually exclusive except we with en_init (INIT) or en_ins (WRITE).
REQ-031 Per-cell latency SHALL be (READ cycles) + (MAX cycles) + 1; no idle cycle between cells.
REQ-032 N*|GAP| SHALL be <= 256; larger values are out of range (simulation assertion).

Reset
REQ-033 rst=1 SHALL immediately force IDLE, all outputs 0, k=i=j=0, max=0, regardless of state.
REQ-034 Reset release mid-operation SHALL not resume; a new start is required.

Verification
REQ-035 N=4, GAP=-2, start pulse -> 10 INIT cycles, data_init 0,0,-2,-2,-4,-4,-6,-6,-8,-8 (9'h1F8 last), init_col alternating 0/1.
REQ-036 Fill N=4, signal 3 cycles after READ entry, max_valid immediate -> 16 WRITE pulses, (i,j) row-major (1,1)..(4,4), one done pulse, busy low after.
REQ-037 max_valid delayed 5 cycles, max_in=9'h1FD -> max_req high 5 cycles, max=9'h1FD during one-cycle WRITE.
REQ-038 rst asserted asynchronously during MAX at cell (2,3) -> all outputs 0 same instant; start ignored while busy; restart gives INIT from k=0.
REQ-039 start held high continuously -> one full fill, done, then immediate new INIT.
REQ-040 signal pulsed during MAX/WRITE/IDLE -> no state change.
